// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32IM instruction-fetch stage.
package rv32_fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      FETCH,
      FLUSH
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Small fetch buffer of {pc, instr} pairs; head is visible combinationally.
module if_fetch_fifo
   import rv32_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic            clear,
   input  logic [XLEN-1:0] push_pc,
   input  logic [XLEN-1:0] push_instr,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_instr,
   output logic [CW-1:0]   count,
   output logic            empty,
   output logic            full
);

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));
   assign do_push    = push && !full;
   assign do_pop     = pop && !empty;
   assign head_pc    = pc_mem[rd_ptr];
   assign head_instr = instr_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the fetch PC, runs the READ/BUSYWAIT
// handshake, buffers returned words and squashes them on redirect.
module if_fetch_ctrl
   import rv32_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            STALL,
   input  logic            REDIRECT,
   input  logic [XLEN-1:0] REDIRECT_PC,
   output logic            MEM_READ,
   output logic [XLEN-1:0] MEM_ADDRESS,
   input  logic            MEM_BUSYWAIT,
   input  logic [XLEN-1:0] MEM_READDATA,
   output logic            IF_VALID,
   output logic [XLEN-1:0] IF_INSTR,
   output logic [XLEN-1:0] IF_PC
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   fetch_state_t    state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] saved_target;
   logic [XLEN-1:0] target;
   logic            mem_read_q;
   logic            completion;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_instr;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   count_next;
   logic            fifo_empty;
   logic            fifo_full;

   assign target     = {REDIRECT_PC[XLEN-1:2], 2'b00};
   assign completion = mem_read_q && !MEM_BUSYWAIT;
   assign push       = completion && (state == FETCH) && !REDIRECT && !fifo_full;
   assign pop        = !fifo_empty && !STALL && !REDIRECT;
   assign count_next = REDIRECT ? '0 : fifo_count + CW'(push) - CW'(pop);

   assign MEM_READ    = mem_read_q;
   assign MEM_ADDRESS = fetch_pc;
   assign IF_VALID    = !fifo_empty;
   assign IF_INSTR    = fifo_empty ? NOP_INSTR : head_instr;
   assign IF_PC       = fifo_empty ? '0 : head_pc;

   if_fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RESET),
      .push      (push),
      .pop       (pop),
      .clear     (REDIRECT),
      .push_pc   (fetch_pc),
      .push_instr(MEM_READDATA),
      .head_pc   (head_pc),
      .head_instr(head_instr),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // A busy request is never withdrawn: a redirect arriving mid-request parks
   // its target and lets FLUSH swallow the stale word before refetching.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= FETCH;
         fetch_pc     <= RESET_PC;
         saved_target <= '0;
         mem_read_q   <= 1'b0;
      end else if (REDIRECT) begin
         mem_read_q <= 1'b1;
         if (mem_read_q && MEM_BUSYWAIT) begin
            state        <= FLUSH;
            saved_target <= target;
         end else begin
            state    <= FETCH;
            fetch_pc <= target;
         end
      end else if (state == FLUSH) begin
         if (completion) begin
            state    <= FETCH;
            fetch_pc <= saved_target;
         end
      end else begin
         if (completion) fetch_pc <= fetch_pc + 32'd4;
         mem_read_q <= (count_next < DEPTH_C);
      end
   end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller for the RV32IM pipeline IF stage.
- Owns the fetch PC and sequences read requests to a variable-latency instruction memory using a READ/BUSYWAIT handshake.
- Buffers returned words in a small FIFO feeding decode, honours decode stalls, and squashes in-flight and buffered fetches on branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch buffer entries (power of 2, ≥2).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- STALL  in  1  decode cannot accept; head entry is held.
- REDIRECT  in  1  branch/jump taken; flush and refetch.
- REDIRECT_PC  in  32  redirect target.
- MEM_READ  out  1  read request to instruction memory.
- MEM_ADDRESS  out  32  word-aligned fetch address.
- MEM_BUSYWAIT  in  1  memory not yet done.
- MEM_READDATA  in  32  instruction word, valid at completion.
- IF_VALID  out  1  IF_INSTR/IF_PC hold a valid fetched instruction.
- IF_INSTR  out  32  head instruction; NOP 32'h0000_0013 when empty.
- IF_PC  out  32  PC of head instruction; 0 when empty.

Behaviour:
- Reset (async): MEM_READ=0, MEM_ADDRESS=RESET_PC, IF_VALID=0, IF_INSTR=NOP, IF_PC=0, FIFO empty, state=FETCH. Asserting mid-transaction aborts it; MEM_READ drops immediately.
- Completion: a rising edge where MEM_READ=1 and MEM_BUSYWAIT=0. MEM_READDATA is sampled at that edge.
  - A zero-wait memory completes at the first edge, giving 1 word/cycle throughput.
  - Minimum latency is one cycle: IF_VALID rises the cycle after completion.
- MEM_ADDRESS and MEM_READ are held stable from assertion until completion; a request is never withdrawn early (except reset).
- FSM states:
  - FETCH: MEM_READ = (count < FIFO_DEPTH). On completion without redirect: push {fetch_pc, data}; fetch_pc += 4, wrapping 32'hFFFF_FFFC→0.
  - FLUSH: entered when REDIRECT arrives while a request is pending and not completing. MEM_READ stays 1 at the old address; the returning word is discarded; on completion fetch_pc←saved target and the FSM returns to FETCH.
- Redirect rules (REDIRECT beats push/pop in the same cycle):
  - FIFO cleared at the edge; IF_VALID=0 the next cycle.
  - Target bits [1:0] forced to 0.
  - No request pending, or request completing this edge: completing data discarded; fetch_pc←target; stay FETCH; next cycle MEM_ADDRESS=target.
  - Request pending and busy: save target, go to FLUSH.
  - REDIRECT while already in FLUSH: the new target overwrites the saved one.
- FIFO rules:
  - Pop when IF_VALID=1 and STALL=0.
  - Push and pop together: count unchanged.
  - Full: MEM_READ=0 until a pop. Full cannot occur mid-request, because count rises only on completion.
  - STALL with an empty FIFO has no effect.
- Outputs: IF_INSTR/IF_PC come combinationally from the FIFO head, so they are stable while STALL=1.

Decomposition:
- Package rv32_fetch_pkg: fetch-state enum {FETCH, FLUSH}, NOP_INSTR=32'h0000_0013, XLEN=32.
- Sub-module if_fetch_fifo: synchronous FIFO storing {pc, instr}, with push, pop, clear, count and empty/full flags.

Test Plan:
- Reset release, zero-wait memory returning 0x00100093 at 0x0 and 0x00208113 at 0x4 → MEM_ADDRESS 0x0, 0x4, 0x8 on consecutive cycles; IF_VALID from cycle 2; IF_PC 0x0 then 0x4.
- Memory BUSYWAIT high 3 cycles per read → MEM_ADDRESS stable 4 cycles per word; one instruction every 4 cycles; no duplicates or skips.
- STALL held 5 cycles with FIFO_DEPTH=2 → after 2 pushes MEM_READ=0; IF_INSTR/IF_PC frozen; STALL release drains both in order, then fetch resumes at the next +4 address.
- REDIRECT to 0x103 while a 0x8 read is busy → FSM enters FLUSH; word from 0x8 discarded; next MEM_ADDRESS=0x100; IF_VALID=0 until the 0x100 word returns.
- REDIRECT to 0x200 then 0x300 during the same FLUSH, plus REDIRECT coincident with a completion edge → only 0x300 fetched in the first case; the completing word is dropped and the next address is the target in the second.
- fetch_pc=0xFFFFFFFC, and RESET asserted mid-busy read → wraps to 0x0 after completion; MEM_READ drops immediately and fetch restarts at RESET_PC.
